// File: rtl/vc_allocator_if.sv
// Request/grant bundle between the input buffers and the VC allocator.
// The master side drives requests and releases; the allocator is the slave.
interface vc_allocator_if #(
  parameter int unsigned PORT_NUM = 5,
  parameter int unsigned VC_NUM   = 2
);
  localparam int unsigned VC_SIZE = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
  localparam int unsigned PORT_W  = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;

  logic [PORT_NUM-1:0][VC_NUM-1:0]              request_i;
  logic [PORT_NUM-1:0][VC_NUM-1:0][PORT_W-1:0]  out_port_i;
  logic [PORT_NUM-1:0][VC_NUM-1:0]              idle_downstream_vc_i;
  logic [PORT_NUM-1:0][VC_NUM-1:0]              vc_valid_o;
  logic [PORT_NUM-1:0][VC_NUM-1:0][VC_SIZE-1:0] vc_new_o;
  logic                                         error_o;

  modport master (
    output request_i, out_port_i, idle_downstream_vc_i,
    input  vc_valid_o, vc_new_o, error_o
  );

  modport slave (
    input  request_i, out_port_i, idle_downstream_vc_i,
    output vc_valid_o, vc_new_o, error_o
  );
endinterface

// File: rtl/vc_allocator.sv
// Zero-latency virtual-channel allocator: one grant per output port per cycle.
// Define VC_ALLOC_ROUND_ROBIN_EN for per-port round-robin; default is fixed priority.
module vc_allocator #(
  parameter int unsigned PORT_NUM = 5,
  parameter int unsigned VC_NUM   = 2
) (
  input  logic           clk,
  input  logic           rst,
  vc_allocator_if.slave  va
);
  localparam int unsigned VC_SIZE = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
  localparam int unsigned PORT_W  = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;
  localparam int unsigned N       = PORT_NUM * VC_NUM;
  localparam int unsigned PTR_W   = (N > 1) ? $clog2(N) : 1;

  logic [PORT_NUM-1:0][VC_NUM-1:0]              avail_q, avail_d;
  logic                                         error_q, error_d;
  logic [PORT_NUM-1:0][VC_NUM-1:0]              valid_c;
  logic [PORT_NUM-1:0][VC_NUM-1:0][VC_SIZE-1:0] new_c;
  logic [PORT_NUM-1:0][VC_NUM-1:0]              grant_pv_c;
`ifdef VC_ALLOC_ROUND_ROBIN_EN
  logic [PORT_NUM-1:0][PTR_W-1:0]               ptr_q, ptr_d;
`endif

  // Per output port: pick a requester, hand it the lowest free VC, then fold in releases.
  always_comb begin
    logic found_lo;
    int   win_lo;
    int   win;
    logic free_found;
    int   free_v;
`ifdef VC_ALLOC_ROUND_ROBIN_EN
    logic found_hi;
    int   win_hi;
`endif
    valid_c    = '0;
    new_c      = '0;
    grant_pv_c = '0;
    avail_d    = avail_q;
    error_d    = 1'b0;
`ifdef VC_ALLOC_ROUND_ROBIN_EN
    ptr_d      = ptr_q;
`endif
    for (int p = 0; p < int'(PORT_NUM); p++) begin
      found_lo   = 1'b0;
      win_lo     = 0;
      free_found = 1'b0;
      free_v     = 0;
`ifdef VC_ALLOC_ROUND_ROBIN_EN
      found_hi   = 1'b0;
      win_hi     = 0;
`endif
      for (int v = 0; v < int'(VC_NUM); v++) begin
        if (!free_found && avail_q[p][v]) begin
          free_found = 1'b1;
          free_v     = v;
        end
      end
      for (int r = 0; r < int'(N); r++) begin
        if (va.request_i[r/VC_NUM][r%VC_NUM] &&
            va.out_port_i[r/VC_NUM][r%VC_NUM] == PORT_W'(p)) begin
          if (!found_lo) begin
            found_lo = 1'b1;
            win_lo   = r;
          end
`ifdef VC_ALLOC_ROUND_ROBIN_EN
          // Lowest candidate at or above the pointer; otherwise wrap to lowest overall.
          if (!found_hi && PTR_W'(r) >= ptr_q[p]) begin
            found_hi = 1'b1;
            win_hi   = r;
          end
`endif
        end
      end
`ifdef VC_ALLOC_ROUND_ROBIN_EN
      win = found_hi ? win_hi : win_lo;
`else
      win = win_lo;
`endif
      if (rst && found_lo && free_found) begin
        for (int r = 0; r < int'(N); r++) begin
          if (r == win) begin
            valid_c[r/VC_NUM][r%VC_NUM] = 1'b1;
            new_c[r/VC_NUM][r%VC_NUM]   = VC_SIZE'(free_v);
`ifdef VC_ALLOC_ROUND_ROBIN_EN
            ptr_d[p] = PTR_W'((r + 1) % N);
`endif
          end
        end
        for (int v = 0; v < int'(VC_NUM); v++) begin
          if (v == free_v) grant_pv_c[p][v] = 1'b1;
        end
      end
    end
    for (int p = 0; p < int'(PORT_NUM); p++) begin
      for (int v = 0; v < int'(VC_NUM); v++) begin
        if (va.idle_downstream_vc_i[p][v]) begin
          if (avail_q[p][v] || grant_pv_c[p][v]) error_d = 1'b1;
          avail_d[p][v] = 1'b1;
        end else if (grant_pv_c[p][v]) begin
          avail_d[p][v] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      avail_q <= '1;
      error_q <= 1'b0;
    end else begin
      avail_q <= avail_d;
      error_q <= error_d;
    end
  end

`ifdef VC_ALLOC_ROUND_ROBIN_EN
  always_ff @(posedge clk) begin
    if (!rst) ptr_q <= '0;
    else      ptr_q <= ptr_d;
  end
`endif

  assign va.vc_valid_o = valid_c;
  assign va.vc_new_o   = new_c;
  assign va.error_o    = error_q;
endmodule
